// File: rtl/ctrl_pkg.sv
// Shared control definitions for the five-stage pipeline control unit:
// opcodes, ALUOp encodings and the decoded control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control bundle table, plus whether the op reads rs2.
// Unknown opcodes decode to an all-zero bundle with illegal set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output ctrl_t      o_ctrl,
    output logic       o_uses_rs2
);

    always_comb begin
        o_ctrl     = ctrl_bubble();
        o_uses_rs2 = 1'b0;
        case (i_op)
            OP_R: begin
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_I: begin
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                o_ctrl.alu_op     = ALUOP_FUNCT;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_uses_rs2       = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.alu_op = ALUOP_SUB;
                o_ctrl.branch = 1'b1;
                o_uses_rs2    = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes ID and carries control through ID/EX, EX/MEM, MEM/WB.
// Load-use hazard detection is built only when CTRL_LOAD_USE_EN is defined.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [6:0]           op_i,
    input  logic [REG_AW-1:0]    rs1_i,
    input  logic [REG_AW-1:0]    rs2_i,
    input  logic [REG_AW-1:0]    rd_i,
    input  logic                 eq_i,
    input  logic                 hold_i,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [ALUOP_W-1:0]   ex_alu_op_o,
    output logic                 ex_alu_src_o,
    output logic                 ex_mem_read_o,
    output logic [REG_AW-1:0]    ex_rd_o,
    output logic                 mem_mem_read_o,
    output logic                 mem_mem_write_o,
    output logic                 mem_reg_write_o,
    output logic [REG_AW-1:0]    mem_rd_o,
    output logic                 wb_reg_write_o,
    output logic                 wb_mem_to_reg_o,
    output logic [REG_AW-1:0]    wb_rd_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);

    ctrl_t w_dec;
    logic  w_uses_rs2;
    logic  w_hz;
    logic  w_bubble;
    logic  w_ill_inc;

    // ID/EX
    logic [ALUOP_W-1:0]   r_ex_alu_op;
    logic                 r_ex_alu_src;
    logic                 r_ex_reg_write;
    logic                 r_ex_mem_to_reg;
    logic                 r_ex_mem_read;
    logic                 r_ex_mem_write;
    logic [REG_AW-1:0]    r_ex_rd;
    // EX/MEM
    logic                 r_mem_reg_write;
    logic                 r_mem_mem_to_reg;
    logic                 r_mem_mem_read;
    logic                 r_mem_mem_write;
    logic [REG_AW-1:0]    r_mem_rd;
    // MEM/WB
    logic                 r_wb_reg_write;
    logic                 r_wb_mem_to_reg;
    logic [REG_AW-1:0]    r_wb_rd;

    logic [ILL_CNT_W-1:0] r_ill_cnt;

    ctrl_decode u_decode (
        .i_op       (op_i),
        .o_ctrl     (w_dec),
        .o_uses_rs2 (w_uses_rs2)
    );

`ifdef CTRL_LOAD_USE_EN
    assign w_hz = valid_i & r_ex_mem_read & (r_ex_rd != '0) &
                  ((r_ex_rd == rs1_i) | ((r_ex_rd == rs2_i) & w_uses_rs2));
`else
    // Without interlocks the compiler schedules NOPs; source fields go unread.
    logic w_unused_hz_src;
    assign w_unused_hz_src = ^{rs1_i, rs2_i, w_uses_rs2};
    assign w_hz            = 1'b0;
`endif

    assign stall_o   = w_hz & ~hold_i;
    assign flush_o   = valid_i & w_dec.branch & eq_i & ~w_hz & ~hold_i;
    assign illegal_o = w_dec.illegal;
    assign w_bubble  = w_hz | ~valid_i | w_dec.illegal;
    assign w_ill_inc = valid_i & w_dec.illegal & ~hold_i & ~w_hz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_alu_op      <= '0;
            r_ex_alu_src     <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_to_reg  <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_rd          <= '0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_rd         <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_rd          <= '0;
            r_ill_cnt        <= '0;
        end else if (!hold_i) begin
            r_ex_alu_op      <= w_bubble ? '0 : ALUOP_W'(w_dec.alu_op);
            r_ex_alu_src     <= ~w_bubble & w_dec.alu_src;
            r_ex_reg_write   <= ~w_bubble & w_dec.reg_write;
            r_ex_mem_to_reg  <= ~w_bubble & w_dec.mem_to_reg;
            r_ex_mem_read    <= ~w_bubble & w_dec.mem_read;
            r_ex_mem_write   <= ~w_bubble & w_dec.mem_write;
            r_ex_rd          <= w_bubble ? '0 : rd_i;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_mem_read   <= r_ex_mem_read;
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_rd         <= r_ex_rd;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
            if (w_ill_inc && (r_ill_cnt != '1))
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

    assign ex_alu_op_o     = r_ex_alu_op;
    assign ex_alu_src_o    = r_ex_alu_src;
    assign ex_mem_read_o   = r_ex_mem_read;
    assign ex_rd_o         = r_ex_rd;
    assign mem_mem_read_o  = r_mem_mem_read;
    assign mem_mem_write_o = r_mem_mem_write;
    assign mem_reg_write_o = r_mem_reg_write;
    assign mem_rd_o        = r_mem_rd;
    assign wb_reg_write_o  = r_wb_reg_write;
    assign wb_mem_to_reg_o = r_wb_mem_to_reg;
    assign wb_rd_o         = r_wb_rd;
    assign ill_cnt_o       = r_ill_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations follow whether CTRL_LOAD_USE_EN is defined.
module tb_ctrl_pipe;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'h7F;

`ifdef CTRL_LOAD_USE_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i, valid_i, eq_i, hold_i;
    logic [6:0] op_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic       stall_o, flush_o;
    logic [1:0] ex_alu_op_o;
    logic       ex_alu_src_o, ex_mem_read_o;
    logic [4:0] ex_rd_o, mem_rd_o, wb_rd_o;
    logic       mem_mem_read_o, mem_mem_write_o, mem_reg_write_o;
    logic       wb_reg_write_o, wb_mem_to_reg_o, illegal_o;
    logic [7:0] ill_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .eq_i(eq_i), .hold_i(hold_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_rd_o(ex_rd_o),
        .mem_mem_read_o(mem_mem_read_o), .mem_mem_write_o(mem_mem_write_o),
        .mem_reg_write_o(mem_reg_write_o), .mem_rd_o(mem_rd_o),
        .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_rd_o(wb_rd_o), .illegal_o(illegal_o), .ill_cnt_o(ill_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic e);
        valid_i = v; op_i = op; rs1_i = s1; rs2_i = s2; rd_i = d; eq_i = e;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst_i = 1'b1; hold_i = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) tick();
        chk("rst_ex_mem_read", ex_mem_read_o, 0);
        chk("rst_ill_cnt", ill_cnt_o, 0);
        rst_i = 1'b0;
        tick();
        chk("idle_ex", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o}, 0);
        chk("idle_mem", {mem_mem_read_o, mem_mem_write_o, mem_reg_write_o, mem_rd_o}, 0);
        chk("idle_wb", {wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o}, 0);
        chk("idle_ill_cnt", ill_cnt_o, 0);

        // LW x5 then ADD using x5
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        chk("lw_no_stall", stall_o, 0);
        tick();
        chk("lw_ex", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o}, {2'b10, 1'b1, 1'b1, 5'd5});
        drive(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
        chk("lu_stall", stall_o, LU);
        tick();
        if (LU) begin
            chk("lu_bubble_ex", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o}, 0);
            chk("lu_lw_mem", {mem_mem_read_o, mem_rd_o}, {1'b1, 5'd5});
            chk("lu_stall_drop", stall_o, 0);
            tick();
        end
        chk("add_ex", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o}, {2'b00, 1'b0, 1'b0, 5'd6});
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
        if (!LU) tick();
        chk("lw_wb", {wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o}, {1'b1, 1'b1, 5'd5});
        tick();
        if (LU) tick();
        chk("add_wb", {wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o}, {1'b1, 1'b0, 5'd6});

        // BEQ taken / not taken
        drain();
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd3, 1'b1);
        chk("beq_flush", flush_o, 1);
        tick();
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("beq_ex_aluop", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o}, {2'b01, 1'b0, 1'b0});
        chk("idle_no_flush", flush_o, 0);
        tick(); tick();
        chk("beq_wb_no_write", wb_reg_write_o, 0);
        drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("beq_nt_flush", flush_o, 0);
        tick();

        // Load feeding a branch: stall wins, branch re-evaluates
        drain();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd4, 1'b0);
        tick();
        drive(1'b1, OP_BEQ, 5'd4, 5'd2, 5'd0, 1'b1);
        chk("sb_stall", stall_o, LU);
        chk("sb_flush", flush_o, !LU);
        tick();
        if (LU) begin
            chk("sb_flush_retry", {stall_o, flush_o}, 2'b01);
            tick();
        end

        // Freeze during a load-use hazard
        drain();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd7, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd3, 5'd7, 5'd8, 1'b0);
        hold_i = 1'b1; #1;
        chk("hold_no_stall", {stall_o, flush_o}, 0);
        repeat (4) tick();
        chk("hold_ex_frozen", {ex_mem_read_o, ex_rd_o}, {1'b1, 5'd7});
        chk("hold_mem_frozen", {mem_mem_read_o, mem_rd_o}, 0);
        hold_i = 1'b0; #1;
        chk("hold_rel_stall", stall_o, LU);
        tick();
        chk("hold_rel_mem", {mem_mem_read_o, mem_rd_o}, {1'b1, 5'd7});
        if (LU) begin
            chk("hold_rel_bubble", {ex_mem_read_o, ex_rd_o}, 0);
            chk("hold_rel_stall_once", stall_o, 0);
            tick();
        end
        chk("hold_add_ex", {ex_alu_src_o, ex_rd_o}, {1'b0, 5'd8});

        // SW, I-type rd=0, LW rd=0 never hazards
        drain();
        drive(1'b1, OP_SW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        chk("sw_ex", {ex_alu_op_o, ex_alu_src_o}, {2'b10, 1'b1});
        drive(1'b1, OP_I, 5'd3, 5'd0, 5'd0, 1'b0);
        tick();
        chk("sw_mem_write", {mem_mem_write_o, mem_reg_write_o}, 2'b10);
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        chk("lw0_ex", {ex_mem_read_o, ex_rd_o}, {1'b1, 5'd0});
        chk("i_mem", {mem_mem_write_o, mem_reg_write_o}, 2'b01);
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd2, 1'b0);
        chk("lw0_no_stall", stall_o, 0);
        tick();

        // Illegal opcode: bubbles, counter, freeze, saturation
        drain();
        drive(1'b1, OP_BAD, 5'd5, 5'd6, 5'd9, 1'b0);
        chk("ill_flag", illegal_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill_bubble_ex", {ex_alu_op_o, ex_alu_src_o, ex_mem_read_o, ex_rd_o}, 0);
        end
        chk("ill_cnt3", ill_cnt_o, 3);
        hold_i = 1'b1;
        repeat (2) tick();
        chk("ill_cnt_hold", ill_cnt_o, 3);
        hold_i = 1'b0;
        repeat (251) tick();
        chk("ill_cnt254", ill_cnt_o, 254);
        tick();
        chk("ill_cnt255", ill_cnt_o, 255);
        repeat (46) tick();
        chk("ill_cnt_sat", ill_cnt_o, 255);

        // Reset with a load in flight
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
        tick();
        chk("pre_rst_ex", ex_mem_read_o, 1);
        rst_i = 1'b1;
        tick();
        chk("midrst_ex", {ex_mem_read_o, ex_rd_o}, 0);
        chk("midrst_cnt", ill_cnt_o, 0);
        rst_i = 1'b0;
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("midrst_mem", {mem_mem_read_o, mem_rd_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the five-stage RISC-V core. It decodes the ID-stage opcode and carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and inserts bubbles, resolves BEQ flush requests, and honours a global pipeline freeze. It supersedes the purely combinational opcode decoder, which left outputs latched on unknown opcodes and had no stage tracking.

## Interface
- REG_AW, 5, register-address width
- ALUOP_W, 2, ALUOp field width (must be ≥2)
- ILL_CNT_W, 8, width of saturating illegal-opcode counter
- clk_i  in  1  core clock; all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  ID holds a real instruction
- op_i  in  7  ID opcode
- rs1_i / rs2_i / rd_i  in  REG_AW  ID register fields
- eq_i  in  1  ID register comparator result (rs1==rs2)
- hold_i  in  1  global freeze (e.g. memory miss)
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  kill IF/ID (taken branch)
- ex_alu_op_o  out  ALUOP_W; ex_alu_src_o, ex_mem_read_o  out 1; ex_rd_o  out REG_AW
- mem_mem_read_o, mem_mem_write_o, mem_reg_write_o  out 1; mem_rd_o  out REG_AW
- wb_reg_write_o, wb_mem_to_reg_o  out 1; wb_rd_o  out REG_AW
- illegal_o  out 1 (comb, ID); ill_cnt_o  out ILL_CNT_W

## Operation
- Decode (comb) fields: alu_op, alu_src, reg_write, mem_to_reg, mem_read, mem_write, branch, illegal.
  - R 0110011: src0 rw1 aluop 00.
  - I 0010011: src1 rw1 aluop 10.
  - LW 0000011: src1 rw1 m2r1 mr1 aluop 10.
  - SW 0100011: src1 mw1 aluop 10.
  - BEQ 1100011: branch1 src0 aluop 01.
  - Any other: all fields 0, illegal=1; never hold prior values.
- Source use: rs1 used by all legal ops; rs2 used only by R, SW, BEQ.
- Load-use: hz = valid_i & ex_mem_read & ex_rd≠0 & ((ex_rd==rs1_i) | (ex_rd==rs2_i & uses_rs2)).
- stall_o = hz & ~hold_i. flush_o = valid_i & branch & eq_i & ~hz & ~hold_i.
- ID/EX load value:
  - If hz, or valid_i=0, or illegal: a bubble (all control 0, rd 0).
  - Otherwise: the decoded bundle.
- EX/MEM and MEM/WB copy their previous stage every cycle.
- hold_i=1: every stage register keeps its value, ill_cnt_o is unchanged, stall_o=flush_o=0. hold_i has priority over hz and branch.
- ill_cnt_o increments on valid_i & illegal & ~hold_i & ~hz, and saturates at all-ones.

## Timing
- Decode, stall_o, flush_o, illegal_o are combinational within the ID cycle.
- An instruction's control appears on ex_* 1 cycle after acceptance, mem_* after 2, wb_* after 3.
- A load-use stall lasts exactly one cycle. Next cycle ex_mem_read=0 (bubble), so hz drops unless hold_i intervenes.
- Reset: every registered output is 0 (rd fields 0), ill_cnt_o=0. Combinational outputs follow inputs against the reset-cleared EX stage.
- Reset mid-flight discards all in-flight control. A stall and a branch in the same cycle do not flush; the branch re-evaluates next cycle.

## Configuration
- CTRL_LOAD_USE_EN defined: hazard detection and bubble insertion as above.
- CTRL_LOAD_USE_EN undefined: hz is tied to 0 and stall_o to 0; the compiler must schedule NOPs. All other behaviour is unchanged.

## Structure
- ctrl_pkg holds the shared definitions:
  - opcode localparams OP_R, OP_I, OP_LW, OP_SW, OP_BEQ;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - typedef struct ctrl_t, holding the decode fields;
  - the function ctrl_bubble() returning an all-zero ctrl_t.
- Sub-module ctrl_decode holds the combinational opcode→ctrl_t table plus uses_rs2. ctrl_pipe instantiates it once.

## Test plan
- Reset held 2 cycles, then released with no valid_i → all ex_/mem_/wb_ outputs 0, ill_cnt_o=0.
- Sequence LW rd=5, then ADD rs1=5 (R-type) → stall_o=1 for one cycle. A bubble appears on ex_* and the ADD reaches ex_* one cycle late. With the macro undefined, no stall occurs.
- BEQ with eq_i=1 → flush_o=1 the same cycle; 3 cycles later wb_reg_write_o=0. With eq_i=0, flush_o=0.
- op_i=0x7F, valid_i=1 for 3 cycles → illegal_o=1, bubbles in ex_*, ill_cnt_o=3. Keeping it asserted for 300 cycles saturates the counter at 255.
- hold_i=1 for 4 cycles during an LW→ADD hazard → all registers frozen, stall_o=0. After release, the stall occurs once and resumes correctly.
- SW followed by I-type with rd=0 → mem_mem_write_o=1 at +2 cycles. The rd=0 load never triggers hz.
